bus_arbiter: RTL and testbench

Two-master bus arbiter that sits in front of the slave-select decoder on the system bus. Master 0 is the DMAC and master 1 is the host/testbench master. The block grants the bus to one master at a time using round-robin, and it preempts a master that holds the bus too long. It then decodes the granted master's address into the 5-bit one-hot slave select, which feeds the existing select encoder and read-data mux.

---
 rtl/bus_arbiter.sv | 61 ++++++
 tb/tb_bus_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with hold-time preemption
// and one-hot slave-select decode of the granted master's address.
module bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m_sel,
  output logic [4:0]        slave_sel,
  output logic              addr_err
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = MAX_HOLD > 0 ? HW'(MAX_HOLD - 1) : '0;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, nxt;
  logic last;
  logic [HW-1:0] hold;
  logic [ADDR_W-1:0] addr, region;
  logic both, preempt;
  always_comb begin
    both = m0_req && m1_req;
    preempt = (MAX_HOLD != 0) && both && hold == HMAX;
    nxt = state;
    case (state)
      IDLE: nxt = both ? (last ? GNT0 : GNT1) : m0_req ? GNT0 : m1_req ? GNT1 : IDLE;
      GNT0: nxt = !m0_req ? (m1_req ? GNT1 : IDLE) : preempt ? GNT1 : GNT0;
      GNT1: nxt = !m1_req ? (m0_req ? GNT0 : IDLE) : preempt ? GNT0 : GNT1;
      default: nxt = IDLE;
    endcase
  end
  // last = 1 means m1 owned the bus most recently, so m0 wins the next tie
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold     <= '0;
      m0_grant <= 1'b0;
      m1_grant <= 1'b0;
      m_sel    <= 1'b0;
    end else begin
      state    <= nxt;
      hold     <= (nxt != state || state == IDLE) ? '0 : hold == HMAX ? hold : hold + 1'b1;
      if (nxt != state && nxt != IDLE) last <= nxt == GNT1;
      m0_grant <= nxt == GNT0;
      m1_grant <= nxt == GNT1;
      if (nxt != IDLE) m_sel <= nxt == GNT1;
    end
  assign addr   = state == GNT1 ? m1_addr : m0_addr;
  assign region = addr >> 8;
  assign slave_sel = state == IDLE ? 5'b00000 :
                     {region == ADDR_W'(0), region == ADDR_W'(1), region == ADDR_W'(2),
                      region == ADDR_W'(3), region == ADDR_W'(4)};
  assign addr_err = state != IDLE && region > ADDR_W'(4);
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random stimulus against two arbiter instances
// (MAX_HOLD = 4 and MAX_HOLD = 0) checked by an owner-level behavioural model.
module tb_bus_arbiter;
  logic clk = 1'b0, reset = 1'b1, m0_req = 1'b0, m1_req = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [1:0] g0, g1, ms, ae;
  logic [4:0] ss [2];
  int checks = 0, failures = 0;
  int own [2], lst [2], cyc [2], msl [2];

  bus_arbiter #(.ADDR_W(16), .MAX_HOLD(4)) u_a (
    .clk(clk), .reset(reset), .m0_req(m0_req), .m0_addr(m0_addr), .m1_req(m1_req), .m1_addr(m1_addr),
    .m0_grant(g0[0]), .m1_grant(g1[0]), .m_sel(ms[0]), .slave_sel(ss[0]), .addr_err(ae[0]));
  bus_arbiter #(.ADDR_W(16), .MAX_HOLD(0)) u_b (
    .clk(clk), .reset(reset), .m0_req(m0_req), .m0_addr(m0_addr), .m1_req(m1_req), .m1_addr(m1_addr),
    .m0_grant(g0[1]), .m1_grant(g1[1]), .m_sel(ms[1]), .slave_sel(ss[1]), .addr_err(ae[1]));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // owner: 0 = nobody, 1 = m0, 2 = m1; cyc = cycles owned so far
  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 0; lst[k] = 2; cyc[k] = 0; msl[k] = 0;
    end
  endtask

  task automatic mstep(int k, int h);
    int o, n;
    bit mine, oth;
    o = own[k];
    if (o == 0) n = (m0_req && m1_req) ? (lst[k] == 2 ? 1 : 2) : m0_req ? 1 : m1_req ? 2 : 0;
    else begin
      mine = o == 1 ? m0_req : m1_req;
      oth  = o == 1 ? m1_req : m0_req;
      n = !mine ? (oth ? 3 - o : 0) : (oth && h != 0 && cyc[k] >= h) ? 3 - o : o;
    end
    cyc[k] = (n != 0 && n == o) ? cyc[k] + 1 : 1;
    if (n != 0 && n != o) lst[k] = n;
    if (n != 0) msl[k] = (n == 2) ? 1 : 0;
    own[k] = n;
  endtask

  task automatic mcompare(int k);
    int a, rg, es;
    logic [31:0] e, act;
    a  = own[k] == 2 ? int'(m1_addr) : int'(m0_addr);
    rg = a >> 8;
    es = (own[k] == 0 || rg > 4) ? 0 : 16 >> rg;
    e   = {23'd0, own[k] == 1, own[k] == 2, msl[k][0], es[4:0], own[k] != 0 && rg > 4};
    act = {23'd0, g0[k], g1[k], ms[k], ss[k], ae[k]};
    chk(k == 0 ? "model_hold4" : "model_hold0", act, e);
  endtask

  task automatic step();
    @(posedge clk);
    mstep(0, 4);
    mstep(1, 0);
    @(negedge clk);
    mcompare(0);
    mcompare(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mreset();
    @(negedge clk);
    mcompare(0);
    mcompare(1);
    reset = 1'b0;
  endtask

  logic [15:0] at [7] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'hFF00};
  logic [5:0]  et [7] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b000001};

  initial begin
    int n;
    do_reset();
    repeat (2) step();
    chk("reset_idle_outs", {g0, g1, ms, ae}, 0);
    chk("reset_idle_sel", {ss[0], ss[1]}, 0);
    m0_req = 1'b1;
    step();
    chk("gnt0_before_reset", g0[0], 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_drop", {g0, g1}, 0);
    mreset();
    m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) step();
    chk("post_reset_idle", {g0, g1, ms, ae, ss[0]}, 0);
    m1_addr = 16'h0312;
    m1_req = 1'b1;
    step();
    chk("single_m1_grant", {g0[0], g1[0], ms[0]}, 3'b011);
    chk("single_m1_sel", ss[0], 5'b00010);
    m1_req = 1'b0;
    step();
    chk("single_m1_release", {g1[0], ss[0]}, 0);
    chk("msel_holds_idle", ms[0], 1);
    do_reset();
    m0_req = 1'b1;
    m1_req = 1'b1;
    step();
    chk("tie_m0_first", {g0[0], g1[0]}, 2'b10);
    m0_req = 1'b0;
    step();
    chk("direct_handoff", {g0[0], g1[0]}, 2'b01);
    m1_req = 1'b0;
    step();
    chk("handoff_release", {g0[0], g1[0]}, 0);
    m0_req = 1'b1;
    m1_req = 1'b1;
    step();
    chk("tie_after_m1", {g0[0], g1[0]}, 2'b10);
    do_reset();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n += int'(g0[0]);
    end
    chk("preempt_hold_cycles", n, 4);
    step();
    chk("preempt_to_m1", {g0[0], g1[0]}, 2'b01);
    chk("no_preempt_hold0", {g0[1], g1[1]}, 2'b10);
    repeat (4) step();
    chk("preempt_back_m0", {g0[0], g1[0]}, 2'b10);
    repeat (16) step();
    chk("hold0_keeps_bus", {g0[1], g1[1]}, 2'b10);
    do_reset();
    m1_req = 1'b0;
    m0_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      m0_addr = at[i];
      step();
      chk("decode_sweep", {ss[0], ae[0]}, et[i]);
    end
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n += int'(g0[0] & ~g1[0]);
    end
    chk("lone_requester_hold", n, 12);
    for (int i = 0; i < 300; i++) begin
      m0_req  = $urandom_range(0, 3) != 0;
      m1_req  = $urandom_range(0, 3) != 0;
      m0_addr = 16'($urandom_range(0, 16'h07FF));
      m1_addr = 16'($urandom_range(0, 16'h07FF));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
